div_ratio_monitor: RTL and testbench
====================================

// Module: div_ratio_monitor
// PURPOSE
//  Receive-side checker for divided clocks produced on-chip (e.g. 50%-duty odd dividers).
//  Oversamples sig_in on a faster clk, measures high/low run lengths, checks period and duty
//  against programmable targets, reports lock and sticky error. Sits in user_module beside dividers.
// PARAMETERS
//  CNT_W        8  width of run-length counters (max run 2^CNT_W-1 clk cycles)
//  SYNC_STAGES  2  synchronizer flops on sig_in (>=2)
//  LOCK_COUNT   4  consecutive good periods required to assert locked
// PORTS
//  clk          in   1        sampling clock (io_in[0] at top)
//  rst          in   1        reset, asynchronous, active-high (io_in[1] at top)
//  sig_in       in   1        asynchronous signal under test
//  exp_period   in   CNT_W+1  expected period in clk cycles
//  tol_per      in   2        allowed |period-exp_period|
//  tol_duty     in   2        allowed |hi_len-lo_len|
//  clr_err      in   1        synchronous clear of err
//  locked       out  1        LOCK_COUNT consecutive good periods seen
//  err          out  1        sticky: bad period or stuck input since last clr_err
//  eval_pulse   out  1        1-cycle strobe: a period was just evaluated
//  period_ok    out  1        result of last evaluation (valid with/after eval_pulse)
//  meas_period  out  CNT_W+1  last measured period (hi_len+lo_len)
// BEHAVIOUR
//  - Reset: all flops 0; outputs locked=0 err=0 eval_pulse=0 period_ok=0 meas_period=0; state ACQUIRE.
//  - sig_in -> SYNC_STAGES flops -> s; s_d = s delayed 1; rise = s&~s_d, fall = ~s&s_d.
//  - run_cnt: loads 1 on rise|fall, else increments, saturating at 2^CNT_W-1.
//  - fall: hi_len <= run_cnt (pre-load value). rise: lo_len <= run_cnt.
//  - States: ACQUIRE -> on rise -> MEASURE (discard partial first run).
//    MEASURE -> on next rise (full hi+lo captured) -> TRACK with evaluation.
//    TRACK -> evaluate on every rise; stays TRACK unless stuck.
//  - Evaluation (registered, results appear cycle after rise): period = hi_len+lo_len, CNT_W+1 bits,
//    no overflow; lo_len term uses run_cnt directly. ok = |period-exp_period|<=tol_per AND
//    |hi_len-lo_len|<=tol_duty (unsigned abs-diff, no wrap). meas_period<=period, period_ok<=ok,
//    eval_pulse=1 for one cycle.
//  - good_cnt (sat. at LOCK_COUNT): ok -> +1; !ok -> 0. locked = (good_cnt==LOCK_COUNT), registered.
//  - !ok: err<=1, locked<=0 same cycle as eval_pulse.
//  - Stuck: run_cnt saturated in MEASURE/TRACK -> err<=1, locked<=0, good_cnt<=0, state ACQUIRE,
//    no eval_pulse. Stuck in ACQUIRE: no error (input never started).
//  - clr_err and error-set same cycle: set wins, err stays 1.
//  - exp_period/tol_* sampled only at evaluation; changes mid-period take effect next rise.
//  - Latency sig_in edge -> eval_pulse: SYNC_STAGES+2 clk cycles.
//  - rst mid-operation: immediate return to reset values regardless of clk.
// STRUCTURE
//  - Package div_mon_pkg: state encodings (ACQUIRE=2'd0, MEASURE=2'd1, TRACK=2'd2),
//    CNT_W default, abs-diff function.
//  - Sub-module sync_edge_det (SYNC_STAGES synchronizer + rise/fall outputs, async rst).
//  - Top: run counter, capture regs, evaluator, FSM, lock counter in one module.
// TESTING
//  1. sig_in 3 hi/3 lo, exp_period=6, tol=0 -> meas_period=6, period_ok=1, locked=1
//     after 4th evaluation, err=0.
//  2. sig_in 4 hi/2 lo, exp_period=6, tol_duty=1 -> period_ok=0, err=1, locked=0;
//     tol_duty=2 -> ok, locks after 4.
//  3. Period 7 (4/3), exp_period=6, tol_per=1, tol_duty=1 -> ok; exp_period=9 -> err=1.
//  4. Locked, then sig_in held high 300 cycles (CNT_W=8) -> err=1, locked=0, ACQUIRE;
//     resume toggling -> relock after ACQUIRE+MEASURE+4 periods.
//  5. clr_err asserted in same cycle as bad-period eval -> err remains 1; next cycle clr -> 0.
//  6. rst pulse mid-lock (between clk edges) -> all outputs 0 at once; first eval only after
//     one discarded partial run plus a full period.

Source files
------------

// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock ratio monitor.
// The FSM state encoding, the default counter width and the unsigned abs-diff helper live here.
package div_mon_pkg;

  localparam int CNT_W_DEF = 8;
  // Wide enough for any CNT_W+1 period and 2-bit tolerances.
  localparam int DIFF_W = 16;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2
  } mon_state_t;

  function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                 input logic [DIFF_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/div_ratio_monitor_if.sv
// Signal bundle between the monitor and its user.
// The master drives the signal under test and the targets; the slave returns the status.
interface div_ratio_monitor_if
  import div_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             sig_in;
  logic [CNT_W:0]   exp_period;
  logic [1:0]       tol_per;
  logic [1:0]       tol_duty;
  logic             clr_err;
  logic             locked;
  logic             err;
  logic             eval_pulse;
  logic             period_ok;
  logic [CNT_W:0]   meas_period;

  modport master (
    output sig_in, exp_period, tol_per, tol_duty, clr_err,
    input  locked, err, eval_pulse, period_ok, meas_period
  );

  modport slave (
    input  sig_in, exp_period, tol_per, tol_duty, clr_err,
    output locked, err, eval_pulse, period_ok, meas_period
  );
endinterface

// File: rtl/div_ratio_monitor_sync_edge_det.sv
// Synchronizer chain for an asynchronous input followed by registered edge detection.
// o_rise/o_fall are one-cycle strobes SYNC_STAGES+1 clk edges after the input moves.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_in;
  logic                   w_s;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;

  assign w_sync_in = {r_sync[SYNC_STAGES-2:0], i_sig};
  assign w_s       = r_sync[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync[gi] <= 1'b0;
        else     r_sync[gi] <= w_sync_in[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s_d  <= w_s;
      r_rise <= w_s & ~r_s_d;
      r_fall <= ~w_s & r_s_d;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/div_ratio_monitor.sv
// Oversampling checker for an on-chip divided clock: measures high/low run lengths,
// compares period and duty against targets, and reports lock plus a sticky error.
module div_ratio_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input logic              clk,
  input logic              rst,
  div_ratio_monitor_if.slave bus
);
  localparam int                GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic              w_rise;
  logic              w_fall;
  logic              w_run_sat;
  logic              w_eval;
  logic              w_stuck;
  logic              w_ok;
  logic [CNT_W:0]    w_period;
  logic [DIFF_W-1:0] w_per_diff;
  logic [DIFF_W-1:0] w_duty_diff;
  logic [GOOD_W-1:0] w_good_next;
  mon_state_t        w_state_next;

  mon_state_t        r_state;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [CNT_W-1:0]  r_hi_len;
  logic [GOOD_W-1:0] r_good_cnt;
  logic              r_locked;
  logic              r_err;
  logic              r_eval_pulse;
  logic              r_period_ok;
  logic [CNT_W:0]    r_meas_period;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_det (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (bus.sig_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_run_sat = (r_run_cnt == CNT_MAX);

  // The low run is evaluated on the rise that ends it, so run_cnt stands in for lo_len.
  assign w_period    = {1'b0, r_hi_len} + {1'b0, r_run_cnt};
  assign w_per_diff  = abs_diff(DIFF_W'(w_period), DIFF_W'(bus.exp_period));
  assign w_duty_diff = abs_diff(DIFF_W'(r_hi_len), DIFF_W'(r_run_cnt));
  assign w_ok        = (w_per_diff <= DIFF_W'(bus.tol_per)) &&
                       (w_duty_diff <= DIFF_W'(bus.tol_duty));
  assign w_good_next = !w_ok ? '0 :
                       (r_good_cnt == GOOD_MAX) ? GOOD_MAX : r_good_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACQUIRE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_eval       = 1'b0;
    w_stuck      = 1'b0;
    unique case (r_state)
      ACQUIRE: begin
        if (w_rise) w_state_next = MEASURE;
      end
      MEASURE, TRACK: begin
        // A saturated run means the input stopped toggling; that outranks a coincident rise.
        if (w_run_sat) begin
          w_stuck      = 1'b1;
          w_state_next = ACQUIRE;
        end else if (w_rise) begin
          w_eval       = 1'b1;
          w_state_next = TRACK;
        end
      end
      default: w_state_next = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_cnt <= '0;
      r_hi_len  <= '0;
    end else begin
      if (w_rise || w_fall)  r_run_cnt <= CNT_W'(1);
      else if (!w_run_sat)   r_run_cnt <= r_run_cnt + 1'b1;
      if (w_fall)            r_hi_len  <= r_run_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_good_cnt    <= '0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_eval_pulse  <= 1'b0;
      r_period_ok   <= 1'b0;
      r_meas_period <= '0;
    end else begin
      r_eval_pulse <= w_eval;
      if (w_eval) begin
        r_meas_period <= w_period;
        r_period_ok   <= w_ok;
        r_good_cnt    <= w_good_next;
        r_locked      <= (w_good_next == GOOD_MAX);
      end else if (w_stuck) begin
        r_good_cnt <= '0;
        r_locked   <= 1'b0;
      end
      if (w_stuck || (w_eval && !w_ok)) r_err <= 1'b1;
      else if (bus.clr_err)             r_err <= 1'b0;
    end
  end

  assign bus.locked      = r_locked;
  assign bus.err         = r_err;
  assign bus.eval_pulse  = r_eval_pulse;
  assign bus.period_ok   = r_period_ok;
  assign bus.meas_period = r_meas_period;
endmodule

// File: tb/tb_div_ratio_monitor.sv
// Directed bench for div_ratio_monitor: continuous divided-clock waveforms with
// hand-computed period/duty outcomes, lock sequencing, stuck input, clear races and async reset.
module tb_div_ratio_monitor;
  import div_mon_pkg::*;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   eval_cnt = 0;
  int   base;

  always #5 clk = ~clk;

  div_ratio_monitor_if #(.CNT_W(CNT_W)) bus ();

  div_ratio_monitor #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    if (bus.eval_pulse === 1'b1) eval_cnt <= eval_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives n full periods: hi cycles high then lo cycles low, back to back.
  task automatic do_periods(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      bus.sig_in = 1'b1;
      repeat (hi) tick();
      bus.sig_in = 1'b0;
      repeat (lo) tick();
    end
    $display("periods %0d/%0d x%0d exp=%0d tp=%0d td=%0d -> meas=%0d ok=%0b locked=%0b err=%0b evals=%0d",
             hi, lo, n, bus.exp_period, bus.tol_per, bus.tol_duty, bus.meas_period,
             bus.period_ok, bus.locked, bus.err, eval_cnt);
  endtask

  initial begin
    bus.sig_in     = 1'b0;
    bus.exp_period = 9'd6;
    bus.tol_per    = 2'd0;
    bus.tol_duty   = 2'd0;
    bus.clr_err    = 1'b0;

    #2 rst = 1'b1;
    tick();
    tick();
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_eval", 32'(bus.eval_pulse), 32'd0);
    check("rst_ok", 32'(bus.period_ok), 32'd0);
    check("rst_meas", 32'(bus.meas_period), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ACQUIRE));
    rst = 1'b0;
    tick();

    // 3/3 against exp 6, zero tolerance: first rise only acquires
    base = eval_cnt;
    do_periods(3, 3, 4);
    check("s1_evals3", 32'(eval_cnt - base), 32'd3);
    check("s1_nolock3", 32'(bus.locked), 32'd0);
    check("s1_ok", 32'(bus.period_ok), 32'd1);
    check("s1_meas", 32'(bus.meas_period), 32'd6);
    do_periods(3, 3, 1);
    check("s1_evals4", 32'(eval_cnt - base), 32'd4);
    check("s1_locked", 32'(bus.locked), 32'd1);
    check("s1_err", 32'(bus.err), 32'd0);

    // 4/2: duty diff 2 exceeds tol 1
    bus.tol_duty = 2'd1;
    do_periods(4, 2, 3);
    check("s2_meas", 32'(bus.meas_period), 32'd6);
    check("s2_bad_ok", 32'(bus.period_ok), 32'd0);
    check("s2_err", 32'(bus.err), 32'd1);
    check("s2_unlock", 32'(bus.locked), 32'd0);
    bus.tol_duty = 2'd2;
    do_periods(4, 2, 4);
    check("s2_good_ok", 32'(bus.period_ok), 32'd1);
    check("s2_relock", 32'(bus.locked), 32'd1);
    check("s2_err_sticky", 32'(bus.err), 32'd1);
    bus.clr_err = 1'b1;
    do_periods(4, 2, 1);
    bus.clr_err = 1'b0;
    check("s2_clr", 32'(bus.err), 32'd0);
    check("s2_lock_kept", 32'(bus.locked), 32'd1);

    // 4/3 = period 7 against exp 6 with tol_per 1, tol_duty 1
    bus.tol_per = 2'd1;
    do_periods(4, 3, 1);
    bus.tol_duty = 2'd1;
    do_periods(4, 3, 4);
    check("s3_meas", 32'(bus.meas_period), 32'd7);
    check("s3_ok", 32'(bus.period_ok), 32'd1);
    check("s3_err", 32'(bus.err), 32'd0);
    check("s3_locked", 32'(bus.locked), 32'd1);
    bus.exp_period = 9'd9;
    do_periods(4, 3, 2);
    check("s3_exp9_meas", 32'(bus.meas_period), 32'd7);
    check("s3_exp9_ok", 32'(bus.period_ok), 32'd0);
    check("s3_exp9_err", 32'(bus.err), 32'd1);
    check("s3_exp9_unlock", 32'(bus.locked), 32'd0);

    // clr_err on the very edge of a bad evaluation: set wins; eval 4 edges after the drive
    bus.sig_in = 1'b1;
    tick();
    tick();
    tick();
    check("s5_lat_early", 32'(bus.eval_pulse), 32'd0);
    bus.clr_err = 1'b1;
    tick();
    check("s5_lat_pulse", 32'(bus.eval_pulse), 32'd1);
    check("s5_bad_ok", 32'(bus.period_ok), 32'd0);
    check("s5_set_wins", 32'(bus.err), 32'd1);
    bus.sig_in = 1'b0;
    tick();
    check("s5_pulse_1cyc", 32'(bus.eval_pulse), 32'd0);
    check("s5_clr_next", 32'(bus.err), 32'd0);
    bus.clr_err = 1'b0;
    tick();
    tick();

    // Relock on 4/3 with exp 7, then hold high long enough to saturate the run counter
    bus.exp_period = 9'd7;
    bus.tol_per    = 2'd0;
    do_periods(4, 3, 5);
    check("s4_locked", 32'(bus.locked), 32'd1);
    check("s4_err0", 32'(bus.err), 32'd0);
    base = eval_cnt;
    bus.sig_in = 1'b1;
    repeat (300) tick();
    $display("stuck high 300 cycles -> locked=%0b err=%0b evals=%0d", bus.locked, bus.err, eval_cnt - base);
    check("s4_stuck_err", 32'(bus.err), 32'd1);
    check("s4_stuck_unlock", 32'(bus.locked), 32'd0);
    check("s4_stuck_state", 32'(dut.r_state), 32'(ACQUIRE));
    check("s4_stuck_evals", 32'(eval_cnt - base), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("s4_clr", 32'(bus.err), 32'd0);
    base = eval_cnt;
    do_periods(4, 3, 5);
    check("s4_resume_evals", 32'(eval_cnt - base), 32'd3);
    check("s4_resume_nolock", 32'(bus.locked), 32'd0);
    do_periods(4, 3, 1);
    check("s4_relock", 32'(bus.locked), 32'd1);
    check("s4_relock_err", 32'(bus.err), 32'd0);

    // Asynchronous reset between clock edges while locked
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("async reset mid-cycle -> locked=%0b meas=%0d ok=%0b", bus.locked, bus.meas_period, bus.period_ok);
    check("s6_locked", 32'(bus.locked), 32'd0);
    check("s6_meas", 32'(bus.meas_period), 32'd0);
    check("s6_ok", 32'(bus.period_ok), 32'd0);
    check("s6_eval", 32'(bus.eval_pulse), 32'd0);
    check("s6_state", 32'(dut.r_state), 32'(ACQUIRE));
    #1 rst = 1'b0;
    tick();
    base = eval_cnt;
    do_periods(4, 3, 1);
    check("s6_discard", 32'(eval_cnt - base), 32'd0);
    do_periods(4, 3, 1);
    check("s6_first_eval", 32'(eval_cnt - base), 32'd1);
    check("s6_first_meas", 32'(bus.meas_period), 32'd7);
    check("s6_first_ok", 32'(bus.period_ok), 32'd1);
    check("s6_no_lock", 32'(bus.locked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
